// File: rtl/duty_ramp_ctrl.sv
// -----------------------------------------------------------------------------
// duty_ramp_ctrl
//
// Slews the duty value of a 16-clock PWM stage toward a requested target.
// A free-running 4-bit phase counter defines the PWM period. Duty only changes
// on the phase-15 edge, so every new value takes effect from phase 0.
//
// A target accepted with in_bypass=0 ramps duty one LSB at a time. Each step
// is STEP_PERIODS PWM periods apart. A target accepted with in_bypass=1 jumps
// straight to the target at the next period end.
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   asynchronous, active-high reset
//   in_valid    in   new target duty offered
//   in_data     in   [3:0] target duty, 0..15
//   in_bypass   in   jump instead of ramp for the accepted target
//   in_ready    out  target can be accepted this cycle (controller idle)
//   duty        out  [3:0] registered duty for the downstream PWM compare
//   period_end  out  high on phase 15, the last clock of each PWM period
//   busy        out  a ramp or jump is pending
// -----------------------------------------------------------------------------
module duty_ramp_ctrl #(
  parameter int unsigned STEP_PERIODS = 4  // PWM periods per ramp step, 1..255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] in_data,
  input  logic       in_bypass,
  output logic       in_ready,
  output logic [3:0] duty,
  output logic       period_end,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    RAMP_UP,
    RAMP_DOWN,
    JUMP
  } state_t;

  // Compare against STEP_PERIODS-1 so the 8-bit counter never has to hold 256.
  localparam logic [7:0] STEP_LAST = 8'(STEP_PERIODS - 1);

  logic [3:0] r_phase;
  logic [3:0] r_duty;
  logic [3:0] r_target;
  logic [7:0] r_step;
  state_t     r_state;

  logic w_period_end;
  logic w_step_done;

  assign w_period_end = (r_phase == 4'd15);
  // True on the period end that completes the current step.
  assign w_step_done  = w_period_end && (r_step == STEP_LAST);

  // NOTE: sequential state uses non-blocking assignments. Every register then
  // samples the pre-edge values, whatever order the statements are in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase <= 4'd0;
    end else begin
      r_phase <= r_phase + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_duty   <= 4'd0;
      r_target <= 4'd0;
      r_step   <= 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_target <= in_data;
            // A period end in the accept cycle is deliberately not counted.
            r_step   <= 8'd0;
            if (in_bypass) begin
              r_state <= JUMP;
            end else if (in_data > r_duty) begin
              r_state <= RAMP_UP;
            end else if (in_data < r_duty) begin
              r_state <= RAMP_DOWN;
            end
          end
        end

        RAMP_UP: begin
          if (w_step_done) begin
            r_step <= 8'd0;
            r_duty <= r_duty + 4'd1;
            // Leave on the same edge that lands on target, so duty never overshoots.
            if (r_duty + 4'd1 == r_target) begin
              r_state <= IDLE;
            end
          end else if (w_period_end) begin
            r_step <= r_step + 8'd1;
          end
        end

        RAMP_DOWN: begin
          if (w_step_done) begin
            r_step <= 8'd0;
            r_duty <= r_duty - 4'd1;
            if (r_duty - 4'd1 == r_target) begin
              r_state <= IDLE;
            end
          end else if (w_period_end) begin
            r_step <= r_step + 8'd1;
          end
        end

        JUMP: begin
          if (w_period_end) begin
            r_duty  <= r_target;
            r_state <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready   = (r_state == IDLE);
  assign busy       = (r_state != IDLE);
  assign duty       = r_duty;
  assign period_end = w_period_end;

endmodule

// File: tb/tb_duty_ramp_ctrl.sv
// -----------------------------------------------------------------------------
// tb_duty_ramp_ctrl
//
// Self-checking bench for duty_ramp_ctrl with STEP_PERIODS = 4.
//
// The reference model keeps a count of clock edges since reset release and
// handles each accepted target as a schedule:
//   - the k-th period end after accept edge a falls on edge f + 16*(k-1),
//     where f is the first multiple of 16 above a;
//   - ramp step j lands on period end number STEP_PERIODS*j;
//   - a jump lands on the first period end.
// The expected duty at any edge is the start value moved by the number of
// steps that have landed.
// -----------------------------------------------------------------------------
module tb_duty_ramp_ctrl;

  localparam int S = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_bypass;
  logic       in_ready;
  logic [3:0] duty;
  logic       period_end;
  logic       busy;

  always #5 clk = ~clk;

  duty_ramp_ctrl #(.STEP_PERIODS(S)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_bypass  (in_bypass),
    .in_ready   (in_ready),
    .duty       (duty),
    .period_end (period_end),
    .busy       (busy)
  );

  int tests = 0;
  int fails = 0;
  int n;                    // rising edges since reset release
  logic [6:0] got, want;    // {duty, busy, in_ready, period_end}

  // Reference model: one pending operation, described by its schedule.
  int m_base;               // duty before the pending operation
  int m_target;
  bit m_active;
  bit m_byp;
  bit m_up;
  int m_f;                  // edge of the first period end after accept
  int m_end;                // edge on which the operation completes

  function automatic logic [3:0] exp_duty(int nn);
    int pe;
    int steps;
    if (!m_active || nn < m_f) return 4'(m_base);
    if (m_byp) return 4'(m_target);
    pe    = (nn - m_f) / 16 + 1;
    steps = pe / S;
    if (m_up) return (steps >= m_target - m_base) ? 4'(m_target) : 4'(m_base + steps);
    return (steps >= m_base - m_target) ? 4'(m_target) : 4'(m_base - steps);
  endfunction

  function automatic bit exp_busy(int nn);
    return m_active && (nn < m_end);
  endfunction

  task automatic model_reset();
    n        = 0;
    m_base   = 0;
    m_target = 0;
    m_active = 0;
    m_byp    = 0;
    m_up     = 0;
    m_f      = 0;
    m_end    = 0;
  endtask

  // Advance one clock. Update the model for an accept on this edge. Return
  // 1 time unit after the edge, where outputs are sampled and inputs driven.
  task automatic step_clk();
    bit acc;
    acc = in_valid && !exp_busy(n);
    @(posedge clk);
    n++;
    if (acc) begin
      m_target = int'(in_data);
      m_byp    = in_bypass;
      m_f      = (n / 16 + 1) * 16;
      if (in_bypass) begin
        m_active = 1;
        m_end    = m_f;
      end else if (m_target != m_base) begin
        m_active = 1;
        m_up     = (m_target > m_base);
        m_end    = m_f + 16 * (S * (m_up ? m_target - m_base : m_base - m_target) - 1);
      end
    end
    #1;
    if (m_active && n >= m_end) begin
      m_base   = int'(exp_duty(n));
      m_active = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 4'd0;
    in_bypass = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    int pulses;
    int p0;
    int p1;
    // NOTE: stimulus is driven with blocking assignments, away from the clock edge.
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 4'd0;
    in_bypass = 1'b0;
    #12;
    tests++;
    if ({duty, busy, in_ready, period_end} !== 7'b0000_0_1_0) begin
      fails++;
      $display("FAIL reset_hold got %b want 0000010", {duty, busy, in_ready, period_end});
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    pulses = 0;
    p0     = -1;
    p1     = -1;
    repeat (40) begin
      step_clk();
      got  = {duty, busy, in_ready, period_end};
      want = {exp_duty(n), exp_busy(n), !exp_busy(n), (n % 16) == 15};
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL reset_idle n=%0d got %b want %b", n, got, want);
      end
      if (period_end === 1'b1) begin
        if (pulses == 0) p0 = n;
        if (pulses == 1) p1 = n;
        pulses++;
      end
    end
    tests++;
    if (pulses != 2 || p0 != 15 || p1 != 31) begin
      fails++;
      $display("FAIL reset_pe_pulses got count=%0d at %0d,%0d want 2 at 15,31", pulses, p0, p1);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_ramp_up();
    int a;
    int k;
    int chg[3];
    int busy_low;
    logic [3:0] prev;
    in_valid  = 1'b1;
    in_data   = 4'd3;
    in_bypass = 1'b0;
    step_clk();
    a        = n;
    in_valid = 1'b0;
    prev     = duty;
    k        = 0;
    busy_low = -1;
    for (int i = 0; i < 400; i++) begin
      step_clk();
      got  = {duty, busy, in_ready, period_end};
      want = {exp_duty(n), exp_busy(n), !exp_busy(n), (n % 16) == 15};
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL ramp_up_cycle n=%0d got %b want %b", n, got, want);
      end
      if (duty !== prev) begin
        if (k < 3) chg[k] = n;
        k++;
        tests++;
        if (duty !== 4'(prev + 4'd1) || (n % 16) != 0) begin
          fails++;
          $display("FAIL ramp_up_step n=%0d got duty=%0d phase=%0d want duty=%0d phase=0",
                   n, duty, n % 16, prev + 4'd1);
        end
        prev = duty;
      end
      if (busy === 1'b0) begin
        busy_low = n;
        break;
      end
    end
    tests++;
    if (k != 3 || busy_low < 0) begin
      fails++;
      $display("FAIL ramp_up_count got steps=%0d busy_low_edge=%0d want 3 steps and idle", k, busy_low);
    end else begin
      tests++;
      if (chg[0] != (a / 16 + 1) * 16 + 16 * (S - 1) || chg[1] - chg[0] != 64 ||
          chg[2] - chg[1] != 64 || busy_low != chg[2] || in_ready !== 1'b1) begin
        fails++;
        $display("FAIL ramp_up_timing got edges %0d,%0d,%0d busy_low=%0d want first=%0d spacing 64",
                 chg[0], chg[1], chg[2], busy_low, (a / 16 + 1) * 16 + 16 * (S - 1));
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_ramp_down();
    logic [3:0] prev;
    int k;
    bit done;
    // Reach duty = 5 with a jump first.
    in_valid  = 1'b1;
    in_data   = 4'd5;
    in_bypass = 1'b1;
    step_clk();
    in_valid = 1'b0;
    done     = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      step_clk();
      if (busy === 1'b0) done = 1;
    end
    tests++;
    if (duty !== 4'd5 || !done) begin
      fails++;
      $display("FAIL ramp_down_setup got duty=%0d want 5", duty);
    end
    in_valid  = 1'b1;
    in_data   = 4'd2;
    in_bypass = 1'b0;
    step_clk();
    prev = duty;
    k    = 0;
    done = 0;
    for (int i = 0; i < 400; i++) begin
      // Offers made while busy must be ignored.
      in_valid  = ($urandom_range(0, 3) == 0);
      in_data   = 4'($urandom_range(0, 15));
      in_bypass = ($urandom_range(0, 1) == 1);
      step_clk();
      got  = {duty, busy, in_ready, period_end};
      want = {exp_duty(n), exp_busy(n), !exp_busy(n), (n % 16) == 15};
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL ramp_down_cycle n=%0d got %b want %b", n, got, want);
      end
      if (duty !== prev) begin
        k++;
        tests++;
        if (duty !== 4'(prev - 4'd1)) begin
          fails++;
          $display("FAIL ramp_down_step n=%0d got duty=%0d want %0d", n, duty, prev - 4'd1);
        end
        prev = duty;
      end
      if (busy === 1'b0) begin
        done = 1;
        break;
      end
    end
    in_valid = 1'b0;
    repeat (50) begin
      step_clk();
      got  = {duty, busy, in_ready, period_end};
      want = {exp_duty(n), exp_busy(n), !exp_busy(n), (n % 16) == 15};
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL ramp_down_idle n=%0d got %b want %b", n, got, want);
      end
    end
    tests++;
    if (!done || k != 3 || duty !== 4'd2) begin
      fails++;
      $display("FAIL ramp_down_final got duty=%0d steps=%0d done=%0b want duty=2 steps=3", duty, k, done);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_jump();
    int a;
    bit hit;
    do_reset();
    for (int i = 0; i < 20 && (n % 16) != 3; i++) step_clk();
    in_valid  = 1'b1;
    in_data   = 4'd12;
    in_bypass = 1'b1;
    step_clk();
    a        = n;
    in_valid = 1'b0;
    hit      = 0;
    for (int i = 0; i < 40; i++) begin
      step_clk();
      got  = {duty, busy, in_ready, period_end};
      want = {exp_duty(n), exp_busy(n), !exp_busy(n), (n % 16) == 15};
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL jump_cycle n=%0d got %b want %b", n, got, want);
      end
      if (duty === 4'd12) begin
        hit = 1;
        break;
      end
    end
    tests++;
    if (!hit || n - a != 12 || (n % 16) != 0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL jump_latency got edges=%0d phase=%0d busy=%0b want 12 edges phase=0 busy=0",
               n - a, n % 16, busy);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_accept_phase15();
    int t0;
    bit hit;
    for (int i = 0; i < 20 && (n % 16) != 15; i++) step_clk();
    t0        = n;   // this sampled cycle is phase 15 and is the accept cycle
    in_valid  = 1'b1;
    in_data   = 4'd13;
    in_bypass = 1'b0;
    step_clk();
    in_valid = 1'b0;
    hit      = 0;
    for (int i = 0; i < 200; i++) begin
      step_clk();
      got  = {duty, busy, in_ready, period_end};
      want = {exp_duty(n), exp_busy(n), !exp_busy(n), (n % 16) == 15};
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL phase15_cycle n=%0d got %b want %b", n, got, want);
      end
      if (duty !== 4'd12) begin
        hit = 1;
        break;
      end
    end
    tests++;
    if (!hit || duty !== 4'd13 || n - t0 != S * 16 + 1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL phase15_latency got duty=%0d clocks=%0d busy=%0b want duty=13 clocks=%0d busy=0",
               duty, n - t0, busy, S * 16 + 1);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid();
    bit hit;
    do_reset();
    in_valid  = 1'b1;
    in_data   = 4'd6;
    in_bypass = 1'b1;
    step_clk();
    in_valid = 1'b0;
    for (int i = 0; i < 40 && busy !== 1'b0; i++) step_clk();
    in_data   = 4'd12;
    in_bypass = 1'b0;
    in_valid  = 1'b1;
    step_clk();
    in_valid = 1'b0;
    hit      = 0;
    for (int i = 0; i < 200; i++) begin
      step_clk();
      got  = {duty, busy, in_ready, period_end};
      want = {exp_duty(n), exp_busy(n), !exp_busy(n), (n % 16) == 15};
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL reset_mid_ramp n=%0d got %b want %b", n, got, want);
      end
      if (duty === 4'd7) begin
        hit = 1;
        break;
      end
    end
    tests++;
    if (!hit || busy !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_reach got duty=%0d busy=%0b want duty=7 busy=1", duty, busy);
    end
    repeat (5) step_clk();
    // Assert reset between clock edges; outputs must clear without a clock.
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if ({duty, busy, in_ready, period_end} !== 7'b0000_0_1_0) begin
      fails++;
      $display("FAIL reset_mid_async got %b want 0000010", {duty, busy, in_ready, period_end});
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (200) begin
      step_clk();
      got  = {duty, busy, in_ready, period_end};
      want = {exp_duty(n), exp_busy(n), !exp_busy(n), (n % 16) == 15};
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL reset_mid_after n=%0d got %b want %b", n, got, want);
      end
    end
    tests++;
    if (duty !== 4'd0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_final got duty=%0d busy=%0b want 0 0", duty, busy);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_random();
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      in_valid  = ($urandom_range(0, 9) == 0);
      in_data   = 4'($urandom_range(0, 15));
      in_bypass = ($urandom_range(0, 2) == 0);
      step_clk();
      got  = {duty, busy, in_ready, period_end};
      want = {exp_duty(n), exp_busy(n), !exp_busy(n), (n % 16) == 15};
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL random_cycle n=%0d got %b want %b", n, got, want);
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_jump();
    test_accept_phase15();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
